autoc_delay_corr: RTL and testbench

AUTOC_DELAY_CORR -- requirements
Module: autoc_delay_corr

---
 rtl/autoc_delay_corr.sv | 265 ++++++++++++++++++++++++++
 tb/tb_autoc_delay_corr.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/autoc_delay_corr.sv
// autoc_delay_corr: delayed complex autocorrelation with a moving-window sum.
//
// Computes p[n] = x[n] * conj(x[n-D]) at full precision and reports the
// moving sum of the last WINDOW products, once D+WINDOW samples have been seen.
// The pipeline has three stages: sample register, multiply, accumulate.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_stb           sample valid (one sample per asserted cycle, gaps allowed)
//   in_i, in_q       signed complex input sample
//   delay            requested lag D (0 clamps to 1, >MAX_DELAY clamps to MAX_DELAY)
//   clear            synchronous flush; a coincident sample is dropped
//   out_stb          one-cycle result valid, 3 cycles after the primed in_stb
//   corr_i, corr_q   signed moving sum, held between strobes
//   primed           fill counter has reached D+WINDOW
//   pwr              (AUTOC_POWER_EN only) moving sum of |x[n-D]|^2
//
// Optional feature macro: AUTOC_POWER_EN adds the pwr output and its logic.
module autoc_delay_corr #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_DELAY = 64,
    parameter int unsigned WINDOW    = 16,
    localparam int unsigned DW = $clog2(MAX_DELAY) + 1,
    localparam int unsigned AW = 2 * WIDTH + 1 + $clog2(WINDOW)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_stb,
    input  logic signed [WIDTH-1:0] in_i,
    input  logic signed [WIDTH-1:0] in_q,
    input  logic [DW-1:0]           delay,
    input  logic                    clear,
    output logic                    out_stb,
    output logic signed [AW-1:0]    corr_i,
    output logic signed [AW-1:0]    corr_q,
    output logic                    primed
`ifdef AUTOC_POWER_EN
    ,
    output logic signed [AW-1:0]    pwr
`endif
);

    localparam int unsigned PW = 2 * WIDTH + 1;
    localparam int unsigned AD = $clog2(MAX_DELAY);
    localparam int unsigned WA = $clog2(WINDOW);
    localparam int unsigned CW = $clog2(MAX_DELAY + WINDOW + 1);

    // Lag clamping and flush control
    logic [DW-1:0] lag_clamp;
    logic [DW-1:0] lag_q, lag_d;
    logic          lag_chg, flush, accept;
    logic [CW-1:0] tgt_new;

    always_comb begin
        lag_clamp = delay;
        if (delay == '0) begin
            lag_clamp = DW'(1);
        end else if (delay > DW'(MAX_DELAY)) begin
            lag_clamp = DW'(MAX_DELAY);
        end
    end

    assign lag_chg = (lag_clamp != lag_q);
    assign flush   = clear | lag_chg;
    assign accept  = in_stb & ~clear;
    assign tgt_new = CW'(lag_clamp) + CW'(WINDOW);

    // Sample delay line: contents are don't-care after reset, the fill counter masks them.
    logic [2*WIDTH-1:0] dl_mem [MAX_DELAY];
    logic [AD-1:0]      wr_ptr_q, wr_ptr_d, rd_addr;

    // With lag == MAX_DELAY the read hits the slot about to be overwritten (old value).
    assign rd_addr = wr_ptr_q - AD'(lag_clamp);

    always_ff @(posedge clk) begin
        if (accept) begin
            dl_mem[wr_ptr_q] <= {in_i, in_q};
        end
    end

    // Pipeline state
    logic [CW-1:0]           count_q, count_d;
    logic                    s1_vld_q, s1_vld_d, s1_prm_q, s1_prm_d;
    logic signed [WIDTH-1:0] s1_xi_q, s1_xi_d, s1_xq_q, s1_xq_d;
    logic signed [WIDTH-1:0] s1_di_q, s1_di_d, s1_dq_q, s1_dq_d;
    logic                    s2_vld_q, s2_vld_d, s2_prm_q, s2_prm_d;
    logic signed [PW-1:0]    s2_re_q, s2_re_d, s2_im_q, s2_im_d;
    logic signed [PW-1:0]    pl_re_q [WINDOW];
    logic signed [PW-1:0]    pl_re_d [WINDOW];
    logic signed [PW-1:0]    pl_im_q [WINDOW];
    logic signed [PW-1:0]    pl_im_d [WINDOW];
    logic [WA-1:0]           pl_ptr_q, pl_ptr_d;
    logic signed [AW-1:0]    acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic signed [AW-1:0]    corr_re_q, corr_re_d, corr_im_q, corr_im_d;
    logic                    out_stb_q, out_stb_d;
`ifdef AUTOC_POWER_EN
    logic signed [PW-1:0]    s2_pw_q, s2_pw_d;
    logic signed [PW-1:0]    pl_pw_q [WINDOW];
    logic signed [PW-1:0]    pl_pw_d [WINDOW];
    logic signed [AW-1:0]    acc_pw_q, acc_pw_d, pwr_q, pwr_d;
`endif

    always_comb begin
        lag_d     = lag_clamp;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        s1_vld_d  = accept;
        s1_prm_d  = 1'b0;
        s1_xi_d   = s1_xi_q;
        s1_xq_d   = s1_xq_q;
        s1_di_d   = s1_di_q;
        s1_dq_d   = s1_dq_q;
        pl_re_d   = pl_re_q;
        pl_im_d   = pl_im_q;
        pl_ptr_d  = pl_ptr_q;
        acc_re_d  = acc_re_q;
        acc_im_d  = acc_im_q;
        corr_re_d = corr_re_q;
        corr_im_d = corr_im_q;
        out_stb_d = 1'b0;
`ifdef AUTOC_POWER_EN
        pl_pw_d   = pl_pw_q;
        acc_pw_d  = acc_pw_q;
        pwr_d     = pwr_q;
`endif

        // Stage 1: fill counter and sample register. On a lag change the
        // coincident sample is the first sample under the new lag.
        if (flush) begin
            count_d = accept ? CW'(1) : '0;
        end else if (accept && (count_q < tgt_new)) begin
            count_d = count_q + CW'(1);
        end
        if (accept) begin
            wr_ptr_d           = wr_ptr_q + AD'(1);
            s1_xi_d            = in_i;
            s1_xq_d            = in_q;
            {s1_di_d, s1_dq_d} = dl_mem[rd_addr];
            s1_prm_d           = (count_d == tgt_new);
        end

        // Stage 2: full-precision products
        s2_vld_d = s1_vld_q & ~flush;
        s2_prm_d = s1_prm_q;
        s2_re_d  = PW'(s1_xi_q) * PW'(s1_di_q) + PW'(s1_xq_q) * PW'(s1_dq_q);
        s2_im_d  = PW'(s1_xq_q) * PW'(s1_di_q) - PW'(s1_xi_q) * PW'(s1_dq_q);
`ifdef AUTOC_POWER_EN
        s2_pw_d  = PW'(s1_di_q) * PW'(s1_di_q) + PW'(s1_dq_q) * PW'(s1_dq_q);
`endif

        // Stage 3: add newest, subtract oldest. Products built from stale
        // delay-line data cancel out exactly before primed is reached.
        if (flush) begin
            for (int k = 0; k < WINDOW; k++) begin
                pl_re_d[k] = '0;
                pl_im_d[k] = '0;
`ifdef AUTOC_POWER_EN
                pl_pw_d[k] = '0;
`endif
            end
            acc_re_d  = '0;
            acc_im_d  = '0;
            corr_re_d = '0;
            corr_im_d = '0;
`ifdef AUTOC_POWER_EN
            acc_pw_d  = '0;
            pwr_d     = '0;
`endif
        end else if (s2_vld_q) begin
            acc_re_d          = acc_re_q + AW'(s2_re_q) - AW'(pl_re_q[pl_ptr_q]);
            acc_im_d          = acc_im_q + AW'(s2_im_q) - AW'(pl_im_q[pl_ptr_q]);
            pl_re_d[pl_ptr_q] = s2_re_q;
            pl_im_d[pl_ptr_q] = s2_im_q;
`ifdef AUTOC_POWER_EN
            acc_pw_d          = acc_pw_q + AW'(s2_pw_q) - AW'(pl_pw_q[pl_ptr_q]);
            pl_pw_d[pl_ptr_q] = s2_pw_q;
`endif
            pl_ptr_d = pl_ptr_q + WA'(1);
            if (s2_prm_q) begin
                out_stb_d = 1'b1;
                corr_re_d = acc_re_d;
                corr_im_d = acc_im_d;
`ifdef AUTOC_POWER_EN
                pwr_d     = acc_pw_d;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lag_q     <= DW'(1);
            count_q   <= '0;
            wr_ptr_q  <= '0;
            s1_vld_q  <= 1'b0;
            s1_prm_q  <= 1'b0;
            s1_xi_q   <= '0;
            s1_xq_q   <= '0;
            s1_di_q   <= '0;
            s1_dq_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_prm_q  <= 1'b0;
            s2_re_q   <= '0;
            s2_im_q   <= '0;
            for (int k = 0; k < WINDOW; k++) begin
                pl_re_q[k] <= '0;
                pl_im_q[k] <= '0;
            end
            pl_ptr_q  <= '0;
            acc_re_q  <= '0;
            acc_im_q  <= '0;
            corr_re_q <= '0;
            corr_im_q <= '0;
            out_stb_q <= 1'b0;
        end else begin
            lag_q     <= lag_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            s1_vld_q  <= s1_vld_d;
            s1_prm_q  <= s1_prm_d;
            s1_xi_q   <= s1_xi_d;
            s1_xq_q   <= s1_xq_d;
            s1_di_q   <= s1_di_d;
            s1_dq_q   <= s1_dq_d;
            s2_vld_q  <= s2_vld_d;
            s2_prm_q  <= s2_prm_d;
            s2_re_q   <= s2_re_d;
            s2_im_q   <= s2_im_d;
            pl_re_q   <= pl_re_d;
            pl_im_q   <= pl_im_d;
            pl_ptr_q  <= pl_ptr_d;
            acc_re_q  <= acc_re_d;
            acc_im_q  <= acc_im_d;
            corr_re_q <= corr_re_d;
            corr_im_q <= corr_im_d;
            out_stb_q <= out_stb_d;
        end
    end

`ifdef AUTOC_POWER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_pw_q  <= '0;
            for (int k = 0; k < WINDOW; k++) begin
                pl_pw_q[k] <= '0;
            end
            acc_pw_q <= '0;
            pwr_q    <= '0;
        end else begin
            s2_pw_q  <= s2_pw_d;
            pl_pw_q  <= pl_pw_d;
            acc_pw_q <= acc_pw_d;
            pwr_q    <= pwr_d;
        end
    end

    assign pwr = pwr_q;
`endif

    assign out_stb = out_stb_q;
    assign corr_i  = corr_re_q;
    assign corr_q  = corr_im_q;
    assign primed  = (count_q == CW'(lag_q) + CW'(WINDOW));

endmodule

// File: tb/tb_autoc_delay_corr.sv
// Directed testbench for autoc_delay_corr (WIDTH=16, MAX_DELAY=64, WINDOW=16).
module tb_autoc_delay_corr;

    logic               clk;
    logic               rst_n;
    logic               in_stb;
    logic signed [15:0] in_i, in_q;
    logic [6:0]         delay;
    logic               clear;
    logic               out_stb;
    logic signed [36:0] corr_i, corr_q;
    logic               primed;
`ifdef AUTOC_POWER_EN
    logic signed [36:0] pwr;
`endif

    autoc_delay_corr #(
        .WIDTH     (16),
        .MAX_DELAY (64),
        .WINDOW    (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_stb  (in_stb),
        .in_i    (in_i),
        .in_q    (in_q),
        .delay   (delay),
        .clear   (clear),
        .out_stb (out_stb),
        .corr_i  (corr_i),
        .corr_q  (corr_q),
        .primed  (primed)
`ifdef AUTOC_POWER_EN
        ,
        .pwr     (pwr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk, n_fail;
    int cyc, n_out, first_out, last_out, prev_out, last_in;
    logic signed [36:0] ci, cq, cp;
    logic signed [36:0] big;

    // One clock: observe outputs on the falling edge, return 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (out_stb === 1'b1) begin
            n_out++;
            if (first_out < 0) first_out = cyc;
            prev_out = last_out;
            last_out = cyc;
            ci = corr_i;
            cq = corr_q;
`ifdef AUTOC_POWER_EN
            cp = pwr;
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic signed [15:0] si, input logic signed [15:0] sq,
                        input int gap);
        in_stb  = 1'b1;
        in_i    = si;
        in_q    = sq;
        last_in = cyc;
        tick();
        in_stb = 1'b0;
        repeat (gap) tick();
    endtask

    // 100 * j^n
    task automatic rot(input int n, output logic signed [15:0] ri, output logic signed [15:0] rq);
        case (n % 4)
            0:       begin ri = 16'sd100;  rq = 16'sd0;    end
            1:       begin ri = 16'sd0;    rq = 16'sd100;  end
            2:       begin ri = -16'sd100; rq = 16'sd0;    end
            default: begin ri = 16'sd0;    rq = -16'sd100; end
        endcase
    endtask

    task automatic mon_reset();
        n_out = 0; first_out = -1; last_out = -1; prev_out = -1;
        ci = '0; cq = '0; cp = '0;
    endtask

    task automatic reset_dut(input logic [6:0] d);
        delay = d; clear = 1'b0; in_stb = 1'b0; rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        mon_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_stb = 1'b0; clear = 1'b0; delay = 7'd4; in_i = '0; in_q = '0;
        @(posedge clk); #1;
        tick(); tick();
        n_chk++; if (out_stb !== 1'b0) begin n_fail++; $display("FAIL rst_out_stb: got %0b exp 0", out_stb); end
        n_chk++; if (primed !== 1'b0) begin n_fail++; $display("FAIL rst_primed: got %0b exp 0", primed); end
        n_chk++; if (corr_i !== 37'sd0) begin n_fail++; $display("FAIL rst_corr_i: got %0d exp 0", corr_i); end
        n_chk++; if (corr_q !== 37'sd0) begin n_fail++; $display("FAIL rst_corr_q: got %0d exp 0", corr_q); end
`ifdef AUTOC_POWER_EN
        n_chk++; if (pwr !== 37'sd0) begin n_fail++; $display("FAIL rst_pwr: got %0d exp 0", pwr); end
`endif
    endtask

    task automatic test_constant();
        int c20;
        reset_dut(7'd4);
        for (int k = 0; k < 19; k++) send(16'sd100, 16'sd0, 0);
        n_chk++; if (primed !== 1'b0) begin n_fail++; $display("FAIL const_primed19: got %0b exp 0", primed); end
        send(16'sd100, 16'sd0, 0);
        c20 = last_in;
        n_chk++; if (primed !== 1'b1) begin n_fail++; $display("FAIL const_primed20: got %0b exp 1", primed); end
        repeat (4) tick();
        n_chk++; if (n_out != 1) begin n_fail++; $display("FAIL const_nout: got %0d exp 1", n_out); end
        n_chk++; if (first_out != c20 + 3) begin n_fail++; $display("FAIL const_latency: got %0d exp %0d", first_out, c20 + 3); end
        n_chk++; if (ci !== 37'sd160000) begin n_fail++; $display("FAIL const_corr_i: got %0d exp 160000", ci); end
        n_chk++; if (cq !== 37'sd0) begin n_fail++; $display("FAIL const_corr_q: got %0d exp 0", cq); end
`ifdef AUTOC_POWER_EN
        n_chk++; if (cp !== 37'sd160000) begin n_fail++; $display("FAIL const_pwr: got %0d exp 160000", cp); end
`endif
        // Outputs hold between strobes
        repeat (3) tick();
        n_chk++; if (corr_i !== 37'sd160000) begin n_fail++; $display("FAIL const_hold: got %0d exp 160000", corr_i); end
    endtask

    task automatic test_rotation(input logic [6:0] d, input int exp_n,
                                 input logic signed [36:0] ei, input logic signed [36:0] eq);
        logic signed [15:0] ri, rq;
        reset_dut(d);
        for (int n = 0; n < 20; n++) begin
            rot(n, ri, rq);
            send(ri, rq, 0);
        end
        repeat (4) tick();
        n_chk++; if (n_out != exp_n) begin n_fail++; $display("FAIL rot_nout d=%0d: got %0d exp %0d", d, n_out, exp_n); end
        n_chk++; if (ci !== ei) begin n_fail++; $display("FAIL rot_corr_i d=%0d: got %0d exp %0d", d, ci, ei); end
        n_chk++; if (cq !== eq) begin n_fail++; $display("FAIL rot_corr_q d=%0d: got %0d exp %0d", d, cq, eq); end
    endtask

    task automatic test_max_neg();
        big = 37'sd34359738368;  // 2^35
        reset_dut(7'd1);
        for (int k = 0; k < 17; k++) send(-16'sd32768, -16'sd32768, 0);
        repeat (4) tick();
        n_chk++; if (n_out != 1) begin n_fail++; $display("FAIL maxneg_nout: got %0d exp 1", n_out); end
        n_chk++; if (ci !== big) begin n_fail++; $display("FAIL maxneg_corr_i: got %0d exp %0d", ci, big); end
        n_chk++; if (cq !== 37'sd0) begin n_fail++; $display("FAIL maxneg_corr_q: got %0d exp 0", cq); end
`ifdef AUTOC_POWER_EN
        n_chk++; if (cp !== big) begin n_fail++; $display("FAIL maxneg_pwr: got %0d exp %0d", cp, big); end
`endif
    endtask

    task automatic test_clamp_high();
        reset_dut(7'd100);
        for (int k = 0; k < 79; k++) send(16'sd100, 16'sd0, 0);
        repeat (4) tick();
        n_chk++; if (n_out != 0) begin n_fail++; $display("FAIL clamp_hi_early: got %0d exp 0", n_out); end
        send(16'sd100, 16'sd0, 0);
        repeat (4) tick();
        n_chk++; if (n_out != 1) begin n_fail++; $display("FAIL clamp_hi_nout: got %0d exp 1", n_out); end
        n_chk++; if (ci !== 37'sd160000) begin n_fail++; $display("FAIL clamp_hi_corr_i: got %0d exp 160000", ci); end
    endtask

    task automatic test_alternate();
        logic signed [15:0] ri, rq;
        int c20;
        reset_dut(7'd4);
        c20 = 0;
        for (int n = 0; n < 22; n++) begin
            rot(n, ri, rq);
            send(ri, rq, 1);
            if (n == 19) c20 = last_in;
        end
        repeat (4) tick();
        n_chk++; if (n_out != 3) begin n_fail++; $display("FAIL alt_nout: got %0d exp 3", n_out); end
        n_chk++; if (first_out != c20 + 3) begin n_fail++; $display("FAIL alt_latency: got %0d exp %0d", first_out, c20 + 3); end
        n_chk++; if (last_out - prev_out != 2) begin n_fail++; $display("FAIL alt_spacing: got %0d exp 2", last_out - prev_out); end
        n_chk++; if (ci !== 37'sd160000) begin n_fail++; $display("FAIL alt_corr_i: got %0d exp 160000", ci); end
        n_chk++; if (cq !== 37'sd0) begin n_fail++; $display("FAIL alt_corr_q: got %0d exp 0", cq); end
    endtask

    task automatic test_lag_change();
        int base;
        reset_dut(7'd4);
        for (int n = 0; n < 30; n++) send(16'(n), 16'sd0, 0);
        repeat (4) tick();
        // sum n*(n-4), n=14..29
        n_chk++; if (n_out != 11) begin n_fail++; $display("FAIL lag_nout4: got %0d exp 11", n_out); end
        n_chk++; if (ci !== 37'sd6360) begin n_fail++; $display("FAIL lag_corr4: got %0d exp 6360", ci); end
        delay = 7'd8;
        tick();
        n_chk++; if (primed !== 1'b0) begin n_fail++; $display("FAIL lag_primed_drop: got %0b exp 0", primed); end
        base = n_out;
        for (int n = 30; n < 53; n++) send(16'(n), 16'sd0, 0);
        repeat (4) tick();
        n_chk++; if (n_out != base) begin n_fail++; $display("FAIL lag_early_out: got %0d exp %0d", n_out, base); end
        send(16'sd53, 16'sd0, 0);
        n_chk++; if (primed !== 1'b1) begin n_fail++; $display("FAIL lag_primed8: got %0b exp 1", primed); end
        repeat (4) tick();
        // sum n*(n-8), n=38..53
        n_chk++; if (n_out != base + 1) begin n_fail++; $display("FAIL lag_nout8: got %0d exp %0d", n_out, base + 1); end
        n_chk++; if (ci !== 37'sd27640) begin n_fail++; $display("FAIL lag_corr8: got %0d exp 27640", ci); end
        n_chk++; if (cq !== 37'sd0) begin n_fail++; $display("FAIL lag_corr8_q: got %0d exp 0", cq); end
    endtask

    task automatic test_reset_clear();
        int base;
        reset_dut(7'd4);
        for (int k = 0; k < 25; k++) send(16'sd100, 16'sd0, 0);
        rst_n = 1'b0;
        #1;
        n_chk++; if (out_stb !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_stb: got %0b exp 0", out_stb); end
        n_chk++; if (primed !== 1'b0) begin n_fail++; $display("FAIL mid_rst_primed: got %0b exp 0", primed); end
        n_chk++; if (corr_i !== 37'sd0) begin n_fail++; $display("FAIL mid_rst_corr_i: got %0d exp 0", corr_i); end
        n_chk++; if (corr_q !== 37'sd0) begin n_fail++; $display("FAIL mid_rst_corr_q: got %0d exp 0", corr_q); end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        mon_reset();
        for (int k = 0; k < 19; k++) send(16'sd100, 16'sd0, 0);
        repeat (4) tick();
        n_chk++; if (n_out != 0) begin n_fail++; $display("FAIL rst_reprime_early: got %0d exp 0", n_out); end
        send(16'sd100, 16'sd0, 0);
        repeat (4) tick();
        n_chk++; if (n_out != 1) begin n_fail++; $display("FAIL rst_reprime_nout: got %0d exp 1", n_out); end
        n_chk++; if (ci !== 37'sd160000) begin n_fail++; $display("FAIL rst_reprime_corr: got %0d exp 160000", ci); end
        // Two samples in flight, then clear coincident with a sample
        send(16'sd100, 16'sd0, 0);
        send(16'sd100, 16'sd0, 0);
        clear = 1'b1; in_stb = 1'b1; in_i = 16'sd1000; in_q = 16'sd0;
        tick();
        clear = 1'b0; in_stb = 1'b0;
        base = n_out;
        n_chk++; if (primed !== 1'b0) begin n_fail++; $display("FAIL clr_primed: got %0b exp 0", primed); end
        n_chk++; if (corr_i !== 37'sd0) begin n_fail++; $display("FAIL clr_corr_i: got %0d exp 0", corr_i); end
        n_chk++; if (corr_q !== 37'sd0) begin n_fail++; $display("FAIL clr_corr_q: got %0d exp 0", corr_q); end
        repeat (4) tick();
        n_chk++; if (n_out != base) begin n_fail++; $display("FAIL clr_inflight: got %0d exp %0d", n_out, base); end
        for (int k = 0; k < 19; k++) send(16'sd100, 16'sd0, 0);
        n_chk++; if (primed !== 1'b0) begin n_fail++; $display("FAIL clr_sample_dropped: got %0b exp 0", primed); end
        send(16'sd100, 16'sd0, 0);
        n_chk++; if (primed !== 1'b1) begin n_fail++; $display("FAIL clr_reprimed: got %0b exp 1", primed); end
        repeat (4) tick();
        n_chk++; if (n_out != base + 1) begin n_fail++; $display("FAIL clr_nout: got %0d exp %0d", n_out, base + 1); end
        n_chk++; if (ci !== 37'sd160000) begin n_fail++; $display("FAIL clr_corr: got %0d exp 160000", ci); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; last_in = 0;
        mon_reset();
        test_reset();
        test_constant();
        test_rotation(7'd1, 4, 37'sd0, 37'sd160000);
        test_rotation(7'd2, 3, -37'sd160000, 37'sd0);
        test_rotation(7'd0, 4, 37'sd0, 37'sd160000);  // lag 0 behaves as lag 1
        test_max_neg();
        test_clamp_high();
        test_alternate();
        test_lag_change();
        test_reset_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
